// File: rtl/sid_reg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sid_reg_sequencer
//  Description : Bus initiator for the SID register port. Queues timed
//                register commands {wait ticks, rd, addr, data} and replays
//                them into the SID core, paced by the 1 MHz clock enable.
//                Reads are captured and returned through a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module sid_reg_sequencer #(
    parameter int FIFO_DEPTH = 16,
    parameter int WAIT_W     = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ce_1m,
    input  logic                          flush,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [WAIT_W-1:0]             cmd_wait,
    input  logic                          cmd_rd,
    input  logic [4:0]                    cmd_addr,
    input  logic [7:0]                    cmd_data,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [4:0]                    rsp_addr,
    output logic [7:0]                    rsp_data,
    output logic                          sid_we,
    output logic [4:0]                    sid_addr,
    output logic [7:0]                    sid_data,
    input  logic [7:0]                    sid_rdata,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam int c_ENT_W = WAIT_W + 1 + 5 + 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_CAPT  = 3'd3,
        ST_RSP   = 3'd4
    } state_t;

    // Command queue storage and bookkeeping
    logic [c_ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;

    // Sequencer state and the command currently being executed
    state_t             r_state;
    logic [WAIT_W-1:0]  r_cnt;
    logic               r_cur_rd;
    logic [4:0]         r_cur_addr;
    logic [7:0]         r_cur_data;

    // Registered output copies
    logic               r_sid_we;
    logic [4:0]         r_sid_addr;
    logic [7:0]         r_sid_data;
    logic               r_rsp_valid;
    logic [4:0]         r_rsp_addr;
    logic [7:0]         r_rsp_data;

    logic               w_push;
    logic               w_pop;
    logic               w_not_empty;
    logic [c_ENT_W-1:0] w_head;
    logic [WAIT_W-1:0]  w_head_wait;
    logic               w_head_rd;
    logic [4:0]         w_head_addr;
    logic [7:0]         w_head_data;

    // A full queue refuses pushes even if a pop frees a slot this cycle,
    // so readiness depends only on the registered level and flush.
    assign cmd_ready   = (r_level < c_LVL_W'(FIFO_DEPTH)) & ~flush;
    assign w_push      = cmd_valid & cmd_ready;
    assign w_not_empty = (r_level != '0);
    assign w_pop       = (r_state == ST_IDLE) & w_not_empty & ~flush;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_wait = w_head[c_ENT_W-1 -: WAIT_W];
    assign w_head_rd   = w_head[13];
    assign w_head_addr = w_head[12:8];
    assign w_head_data = w_head[7:0];

    assign busy        = (r_state != ST_IDLE) | w_not_empty;
    assign fifo_level  = r_level;
    assign sid_we      = r_sid_we;
    assign sid_addr    = r_sid_addr;
    assign sid_data    = r_sid_data;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_addr    = r_rsp_addr;
    assign rsp_data    = r_rsp_data;

    // Queue storage write; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_wait, cmd_rd, cmd_addr, cmd_data};
        end
    end

    // Queue pointers and occupancy; flush empties the queue in one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // Command sequencer: fetch, count ce_1m ticks, strobe the SID, capture reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cur_rd    <= 1'b0;
            r_cur_addr  <= '0;
            r_cur_data  <= '0;
            r_sid_we    <= 1'b0;
            r_sid_addr  <= '0;
            r_sid_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
        end else if (flush) begin
            // Abort: drop any pending op; sid_addr/sid_data keep their last value
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_sid_we    <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_sid_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_cnt      <= w_head_wait;
                        r_cur_rd   <= w_head_rd;
                        r_cur_addr <= w_head_addr;
                        r_cur_data <= w_head_data;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // wait=N issues on the (N+1)th tick seen here
                    if (ce_1m) begin
                        if (r_cnt == '0) begin
                            r_sid_addr <= r_cur_addr;
                            if (!r_cur_rd) begin
                                r_sid_we   <= 1'b1;
                                r_sid_data <= r_cur_data;
                            end
                            r_state <= ST_ISSUE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_state <= r_cur_rd ? ST_CAPT : ST_IDLE;
                end
                ST_CAPT: begin
                    // sid_rdata is combinational from the address driven in ISSUE
                    r_rsp_data  <= sid_rdata;
                    r_rsp_addr  <= r_sid_addr;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RSP;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sid_reg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sid_reg_sequencer
//  Description : Scoreboard bench for sid_reg_sequencer. Directed command
//                pushes enqueue expected SID writes / read responses; a
//                negedge monitor pops and compares as the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sid_reg_sequencer;

    localparam int FIFO_DEPTH = 16;
    localparam int WAIT_W     = 16;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b0;
    logic              ce_1m     = 1'b0;
    logic              flush     = 1'b0;
    logic              cmd_valid = 1'b0;
    logic [WAIT_W-1:0] cmd_wait  = '0;
    logic              cmd_rd    = 1'b0;
    logic [4:0]        cmd_addr  = '0;
    logic [7:0]        cmd_data  = '0;
    logic              rsp_ready = 1'b0;
    logic              cmd_ready;
    logic              rsp_valid;
    logic [4:0]        rsp_addr;
    logic [7:0]        rsp_data;
    logic              sid_we;
    logic [4:0]        sid_addr;
    logic [7:0]        sid_data;
    logic [7:0]        sid_rdata;
    logic              busy;
    logic [4:0]        fifo_level;

    int          n_vec    = 0;
    int          n_err    = 0;
    int          we_count = 0;
    int          ce_req   = 0;
    int          ce_done  = 0;
    int          div      = 0;
    bit          ce_auto  = 1'b0;
    bit          ce_seen  = 1'b0;
    bit          prev_we  = 1'b0;
    logic [12:0] exp_wr  [$];
    logic [12:0] exp_rsp [$];

    // SID register file model: 0x1B reads 0xA5, everything else addr^0x3C
    assign sid_rdata = (sid_addr == 5'h1B) ? 8'hA5 : ({3'b000, sid_addr} ^ 8'h3C);

    sid_reg_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .WAIT_W(WAIT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce_1m      (ce_1m),
        .flush      (flush),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_wait   (cmd_wait),
        .cmd_rd     (cmd_rd),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_addr   (rsp_addr),
        .rsp_data   (rsp_data),
        .sid_we     (sid_we),
        .sid_addr   (sid_addr),
        .sid_data   (sid_data),
        .sid_rdata  (sid_rdata),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One ce_1m pulse, then enough clocks for a write or a read capture to land
    task automatic ce_tick();
        ce_req++;
        tick(6);
    endtask

    task automatic push(input logic [WAIT_W-1:0] w, input logic rd, input logic [4:0] a,
                        input logic [7:0] d, input logic [7:0] rexp);
        int cyc;
        cyc = 0;
        while (!cmd_ready && cyc < 1000) begin
            tick(1);
            cyc++;
        end
        if (!cmd_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL push timeout: cmd_ready stayed 0 for addr 0x%0h", a);
        end else begin
            cmd_valid = 1'b1;
            cmd_wait  = w;
            cmd_rd    = rd;
            cmd_addr  = a;
            cmd_data  = d;
            tick(1);
            cmd_valid = 1'b0;
            if (rd) exp_rsp.push_back({a, rexp});
            else    exp_wr.push_back({a, d});
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int c;
        c = 0;
        while (busy && c < budget) begin
            tick(1);
            c++;
        end
        chk(name, busy, 1'b0);
    endtask

    // ce_1m source: free-running every 8 clocks, or single requested pulses
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (ce_auto) begin
                div++;
                ce_1m = (div % 8 == 0);
            end else if (ce_done != ce_req) begin
                ce_1m = 1'b1;
                ce_done++;
            end else begin
                ce_1m = 1'b0;
            end
        end
    end

    // Monitor: compare every SID write strobe and every read-response handshake
    initial begin
        forever begin
            @(negedge clk);
            if (sid_we) begin
                we_count++;
                if (exp_wr.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected sid_we: addr 0x%0h data 0x%0h, none expected", sid_addr, sid_data);
                end else begin
                    chk("write addr/data", {sid_addr, sid_data}, exp_wr.pop_front());
                    chk("write single-clk and paced by ce_1m", {prev_we, ce_seen}, 2'b01);
                end
                ce_seen = 1'b0;
            end
            prev_we = sid_we;
            if (ce_1m) ce_seen = 1'b1;
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected response: addr 0x%0h data 0x%0h, none expected", rsp_addr, rsp_data);
                end else begin
                    chk("read response addr/data", {rsp_addr, rsp_data}, exp_rsp.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        // Reset state
        tick(3);
        chk("reset cmd_ready", cmd_ready, 1'b1);
        chk("reset rsp_valid", rsp_valid, 1'b0);
        chk("reset sid_we", sid_we, 1'b0);
        chk("reset sid_addr/data", {sid_addr, sid_data}, 13'h0);
        chk("reset rsp_addr/data", {rsp_addr, rsp_data}, 13'h0);
        chk("reset busy", busy, 1'b0);
        chk("reset fifo_level", fifo_level, 5'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(2);

        // Single write, wait=0: strobe only after the next ce_1m
        base = we_count;
        push(16'd0, 1'b0, 5'h18, 8'h0F, 8'h00);
        tick(3);
        chk("wait0 no write before ce", we_count, base);
        ce_tick();
        chk("wait0 write after ce", we_count, base + 1);
        chk("sid_addr/data held", {sid_addr, sid_data}, {5'h18, 8'h0F});
        chk("sid_we low after strobe", sid_we, 1'b0);

        // wait=3: no strobe on ticks 1..3, strobe on tick 4
        base = we_count;
        push(16'd3, 1'b0, 5'h04, 8'h41, 8'h00);
        tick(3);
        repeat (3) ce_tick();
        chk("wait3 no write after 3 ticks", we_count, base);
        ce_tick();
        chk("wait3 write after 4th tick", we_count, base + 1);

        // Fill the queue with ce_1m held low, then drain in order
        base = we_count;
        for (int i = 0; i < 17; i++) begin
            push(16'd0, 1'b0, 5'(i), 8'(8'h20 + i), 8'h00);
        end
        chk("full fifo_level", fifo_level, 5'd16);
        chk("full cmd_ready", cmd_ready, 1'b0);
        chk("full no writes yet", we_count, base);
        fork
            push(16'd0, 1'b0, 5'h1F, 8'hEE, 8'h00);
            ce_auto = 1'b1;
        join
        wait_idle(1000, "drain busy");
        ce_auto = 1'b0;
        tick(2);
        chk("drain write count", we_count, base + 18);

        // Read with back-pressure; a queued write must wait for the handshake
        base = we_count;
        rsp_ready = 1'b0;
        push(16'd0, 1'b1, 5'h1B, 8'h00, 8'hA5);
        push(16'd0, 1'b0, 5'h05, 8'h77, 8'h00);
        tick(2);
        ce_tick();
        chk("read rsp_valid", rsp_valid, 1'b1);
        chk("read rsp_addr/data", {rsp_addr, rsp_data}, {5'h1B, 8'hA5});
        chk("read fifo_level", fifo_level, 5'd1);
        ce_tick();
        ce_tick();
        chk("read rsp held", {rsp_valid, rsp_addr, rsp_data}, {1'b1, 5'h1B, 8'hA5});
        chk("read no write while pending", we_count, base);
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        tick(1);
        chk("read rsp_valid cleared", rsp_valid, 1'b0);
        ce_tick();
        chk("write after read", we_count, base + 1);
        rsp_ready = 1'b1;
        push(16'd0, 1'b1, 5'h19, 8'h00, 8'h25);
        tick(2);
        ce_tick();
        tick(2);
        chk("second read consumed", rsp_valid, 1'b0);
        chk("sid_addr holds read addr", sid_addr, 5'h19);
        rsp_ready = 1'b0;

        // Flush during WAIT with commands queued; simultaneous push is dropped
        base = we_count;
        for (int i = 0; i < 5; i++) begin
            push(16'd2, 1'b0, 5'(5'h10 + i), 8'(8'h50 + i), 8'h00);
        end
        tick(2);
        chk("pre-flush fifo_level", fifo_level, 5'd4);
        ce_tick();
        flush     = 1'b1;
        cmd_valid = 1'b1;
        cmd_addr  = 5'h1F;
        cmd_data  = 8'hFF;
        cmd_wait  = '0;
        cmd_rd    = 1'b0;
        #1;
        chk("flush cmd_ready", cmd_ready, 1'b0);
        tick(1);
        flush     = 1'b0;
        cmd_valid = 1'b0;
        chk("flush fifo_level", fifo_level, 5'd0);
        chk("flush busy", busy, 1'b0);
        chk("flush sid_we/rsp_valid", {sid_we, rsp_valid}, 2'b00);
        exp_wr.delete();
        repeat (3) ce_tick();
        chk("no write after flush", we_count, base);
        push(16'd0, 1'b0, 5'h0B, 8'h5A, 8'h00);
        tick(2);
        ce_tick();
        chk("write after flush", we_count, base + 1);

        // Asynchronous reset while a response is pending
        base = we_count;
        push(16'd0, 1'b1, 5'h1B, 8'h00, 8'hA5);
        push(16'd0, 1'b0, 5'h02, 8'h33, 8'h00);
        tick(2);
        ce_tick();
        chk("pre-reset rsp_valid", rsp_valid, 1'b1);
        chk("pre-reset fifo_level", fifo_level, 5'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset rsp_valid/sid_we", {rsp_valid, sid_we}, 2'b00);
        chk("async reset fifo_level", fifo_level, 5'd0);
        chk("async reset busy/cmd_ready", {busy, cmd_ready}, 2'b01);
        chk("async reset sid_addr/rsp_data", {sid_addr, rsp_data}, 13'h0);
        exp_rsp.delete();
        exp_wr.delete();
        @(negedge clk);
        reset_n = 1'b1;
        tick(2);
        ce_tick();
        ce_tick();
        chk("no write after reset", we_count, base);
        chk("post-reset fifo_level", fifo_level, 5'd0);

        chk("writes all observed", exp_wr.size(), 0);
        chk("responses all observed", exp_rsp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
